poly_acc_modq: RTL and testbench

Sequential polynomial accumulator that sits directly downstream of the 5-to-1 operand multiplexer in the add path. It captures the multiplexer's full-width polynomial output, then adds it coefficient-wise, modulo q, into an internal accumulator polynomial over several cycles, `LANES` coefficients per cycle. The block builds sums such as t = A·s + e and v = tᵀr + e2 + m one operand at a time, while the upstream selector steps through its inputs.

---
 rtl/poly_acc_modq_if.sv | 24 ++
 rtl/poly_acc_modq.sv | 138 +++++++++++++
 tb/tb_poly_acc_modq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/poly_acc_modq_if.sv
// Operand/result bundle between the operand multiplexer and the modular
// polynomial accumulator.
interface poly_acc_modq_if #(
  parameter int N = 256,
  parameter int W = 12
);
  logic           in_valid;
  logic           in_ready;
  logic           clear;
  logic [N*W-1:0] poly_in;
  logic [N*W-1:0] acc_out;
  logic           out_valid;
  logic           busy;

  modport master (
    output in_valid, clear, poly_in,
    input  in_ready, acc_out, out_valid, busy
  );

  modport slave (
    input  in_valid, clear, poly_in,
    output in_ready, acc_out, out_valid, busy
  );
endinterface

// File: rtl/poly_acc_modq.sv
// Sequential coefficient-wise modular accumulator: latches one operand
// polynomial, then adds it into the accumulator LANES coefficients per cycle.
module poly_acc_modq #(
  parameter int N     = 256,
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int LANES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  poly_acc_modq_if.slave   bus
);

  localparam int CHUNKS = N / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [W:0]    Q_W  = Q[W:0];
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  if (N % LANES != 0) begin : g_lane_check
    $error("poly_acc_modq: N must be a multiple of LANES");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic           clr_r;
  logic [N*W-1:0] acc_r;
  logic [N*W-1:0] op_r;
  logic [N*W-1:0] acc_nxt_s;
  logic           cnt_last_s;

  // One W+1-bit add followed by a single conditional subtraction of Q.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         clr);
    logic [W:0] s;
    logic [W:0] d;
    s = (clr ? {(W+1){1'b0}} : {1'b0, a}) + {1'b0, b};
    d = s - Q_W;
    if (s >= Q_W) begin
      return d[W-1:0];
    end else begin
      return s[W-1:0];
    end
  endfunction

  assign cnt_last_s = (cnt_r == LAST);

  // Next-state decode; IDLE is the only state that accepts an operand.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Lane adders for the chunk currently addressed by cnt_r.
  always_comb begin
    acc_nxt_s = acc_r;
    if (state_r == ST_RUN) begin
      for (int j = 0; j < LANES; j++) begin
        acc_nxt_s[(int'(cnt_r) * LANES + j) * W +: W] =
          mod_add(acc_r[(int'(cnt_r) * LANES + j) * W +: W],
                  op_r[(int'(cnt_r) * LANES + j) * W +: W],
                  clr_r);
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // State register; reset aborts any pass in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, chunk counter and accumulator storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      clr_r <= 1'b0;
      op_r  <= {(N*W){1'b0}};
      acc_r <= {(N*W){1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_r  <= bus.poly_in;
            clr_r <= bus.clear;
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          if (cnt_last_s) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.acc_out   = acc_r;
  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out_valid = (state_r == ST_DONE);

endmodule

// File: tb/tb_poly_acc_modq.sv
// Randomized scoreboard bench for poly_acc_modq: expected polynomials and
// completion cycles are queued at accept and checked when out_valid pulses.
module tb_poly_acc_modq;
  localparam int N     = 256;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int LANES = 16;
  localparam int CH    = N / LANES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  poly_acc_modq_if #(.N(N), .W(W)) bus ();

  poly_acc_modq #(.N(N), .W(W), .Q(Q), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [N*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  int             ref_acc[N];
  logic [N*W-1:0] mon_exp;
  int             mon_cyc;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic compare_poly(input string name, input logic [N*W-1:0] act,
                              input logic [N*W-1:0] req);
    int bad = -1;
    int idx;
    for (int i = 0; i < N; i++)
      if (bad < 0 && act[i*W +: W] !== req[i*W +: W]) bad = i;
    idx = (bad < 0) ? 0 : bad;
    check($sformatf("%s[%0d]", name, idx), act === req,
          longint'(act[idx*W +: W]), longint'(req[idx*W +: W]));
  endtask

  // Reference: plain modular arithmetic on integer coefficients.
  function automatic logic [N*W-1:0] model(input logic [N*W-1:0] p, input logic clr);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) begin
      ref_acc[i] = ((clr ? 0 : ref_acc[i]) + int'(p[i*W +: W])) % Q;
      r[i*W +: W] = W'(ref_acc[i]);
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_poly();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, Q - 1));
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill_poly(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [N*W-1:0] ramp_poly();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(i);
    return r;
  endfunction

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1'b0, 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("out_valid_cycle", cyc == mon_cyc, cyc, mon_cyc);
        compare_poly("acc_result", bus.acc_out, mon_exp);
      end
    end
  end

  // Called at a negedge; returns at the first negedge with in_ready high.
  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 1'b0, 0, 1);
  endtask

  // cyc after the accept edge is C; the DONE cycle is sampled with cyc == C+CH.
  task automatic send(input logic [N*W-1:0] p, input logic clr, input bit scramble);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.poly_in  = p;
    bus.clear    = clr;
    @(posedge clk);
    #1;
    exp_q.push_back(model(p, clr));
    exp_cyc_q.push_back(cyc + CH);
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.poly_in = rand_poly();
      bus.clear   = ~clr;
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] p1;
    logic [N*W-1:0] p2;
    int c0;
    int early;
    int idle;
    int n;

    for (int i = 0; i < N; i++) ref_acc[i] = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.poly_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_poly("reset_acc", bus.acc_out, fill_poly(0));
    check("reset_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
    check("reset_busy", bus.busy === 1'b0, bus.busy, 0);
    check("reset_out_valid", bus.out_valid === 1'b0, bus.out_valid, 0);

    send(ramp_poly(), 1'b1, 1'b0);

    send(fill_poly(Q - 1), 1'b1, 1'b0);
    send(fill_poly(1), 1'b0, 1'b0);
    send(fill_poly(5), 1'b0, 1'b0);
    send(fill_poly(Q - 1), 1'b0, 1'b0);

    send(rand_poly(), 1'b1, 1'b1);
    send(rand_poly(), 1'b0, 1'b1);
    send(rand_poly(), 1'b0, 1'b1);

    // in_valid held high with a different operand for the whole pass.
    wait_ready();
    p1 = rand_poly();
    p2 = rand_poly();
    bus.in_valid = 1'b1;
    bus.poly_in  = p1;
    bus.clear    = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(model(p1, 1'b0));
    exp_cyc_q.push_back(cyc + CH);
    bus.poly_in = p2;
    early = 0;
    idle  = 0;
    for (int k = 0; k <= CH; k++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) early++;
      if (bus.busy !== 1'b1) idle++;
    end
    check("busy_no_early_ready", early == 0, early, 0);
    check("busy_held_high", idle == 0, idle, 0);
    @(negedge clk);
    check("busy_ready_cycle18", bus.in_ready === 1'b1, bus.in_ready, 1);
    @(posedge clk);
    #1;
    exp_q.push_back(model(p2, 1'b0));
    exp_cyc_q.push_back(cyc + CH);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Reset in RUN cycle 8 of a non-clear pass; no result is expected.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.poly_in  = rand_poly();
    bus.clear    = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_poly("midreset_acc", bus.acc_out, fill_poly(0));
    check("midreset_in_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
    check("midreset_busy", bus.busy === 1'b0, bus.busy, 0);
    for (int i = 0; i < N; i++) ref_acc[i] = 0;
    repeat (CH + 4) @(negedge clk);

    send(rand_poly(), 1'b0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
